// File: rtl/ysyx_24120013_ifetch.sv
// Instruction fetch unit: issues one fetch request at a time, holds the returned
// word for the decode stage, and handles redirects that can kill an in-flight fetch.
module ysyx_24120013_ifetch #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pc_jmp_en,
  input  logic [ADDR_WIDTH-1:0] pc_jmp_val,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(32'd3);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(32'd4);

  state_e                state_q,      state_d;
  logic [ADDR_WIDTH-1:0] pc_q,         pc_d;
  logic                  kill_q,       kill_d;
  logic [DATA_WIDTH-1:0] inst_q,       inst_d;
  logic [ADDR_WIDTH-1:0] inst_pc_q,    inst_pc_d;
  logic                  req_valid_q,  req_valid_d;
  logic                  inst_valid_q, inst_valid_d;

  logic [ADDR_WIDTH-1:0] jmp_tgt_s;
  logic                  req_hs_s;
  logic                  inst_hs_s;

  assign jmp_tgt_s = pc_jmp_val & ALIGN_MASK;
  assign req_hs_s  = req_valid_q && mem_req_ready;
  assign inst_hs_s = inst_valid_q && inst_ready;

  // Next-state and datapath updates; pc_q doubles as the in-flight address
  // whenever no kill is pending, so it is latched into inst_pc on delivery.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;

    case (state_q)
      S_REQ: begin
        if (req_hs_s) begin
          state_d = S_WAIT;
          if (pc_jmp_en) begin
            kill_d = 1'b1;
            pc_d   = jmp_tgt_s;
          end else begin
            kill_d = 1'b0;
          end
        end else if (pc_jmp_en) begin
          pc_d = jmp_tgt_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (kill_q || pc_jmp_en) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
            pc_d    = pc_jmp_en ? jmp_tgt_s : pc_q;
          end else begin
            state_d   = S_HOLD;
            inst_d    = mem_rsp_data;
            inst_pc_d = pc_q;
          end
        end else if (pc_jmp_en) begin
          kill_d = 1'b1;
          pc_d   = jmp_tgt_s;
        end else begin
          kill_d = kill_q;
        end
      end
      S_HOLD: begin
        if (pc_jmp_en) begin
          state_d = S_REQ;
          pc_d    = jmp_tgt_s;
        end else if (inst_hs_s) begin
          state_d = S_REQ;
          pc_d    = pc_q + PC_STEP;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase

    req_valid_d  = (state_d == S_REQ);
    inst_valid_d = (state_d == S_HOLD);
  end

  // State and output registers; the valid flags are registered so both are low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      inst_q       <= {DATA_WIDTH{1'b0}};
      inst_pc_q    <= {ADDR_WIDTH{1'b0}};
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = pc_q;
  assign inst_valid    = inst_valid_q;
  assign inst          = inst_q;
  assign inst_pc       = inst_pc_q;

endmodule

// File: tb/tb_ysyx_24120013_ifetch.sv
// Bench for ysyx_24120013_ifetch: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-rule model.
module tb_ysyx_24120013_ifetch;

  logic        clk;
  logic        rst;
  logic        pc_jmp_en;
  logic [31:0] pc_jmp_val;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  logic        auto_mem;
  logic [31:0] rsp_data_drv;
  logic [31:0] mem_last_addr;
  int          delivered;
  int          cyc;
  int          errors;
  int          checks;
  bit          done;

  ysyx_24120013_ifetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_jmp_en    (pc_jmp_en),
    .pc_jmp_val   (pc_jmp_val),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst         (inst),
    .inst_pc      (inst_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Simple memory: the word returned is the last accepted address xor a constant.
  assign mem_rsp_data = auto_mem ? (mem_last_addr ^ 32'h1234_5678) : rsp_data_drv;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req_valid && mem_req_ready) mem_last_addr <= mem_req_addr;
    if (!rst && inst_valid && inst_ready) delivered <= delivered + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_for_inst(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("inst_valid_timeout", 32'd0, 32'd1);
  endtask

  // Reference model: fetch phase 0=requesting, 1=awaiting, 2=holding.
  int          m_phase;
  logic [31:0] m_pc;
  bit          m_kill;
  bit          m_fresh;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;

  initial begin
    bit          exp_req;
    bit          exp_iv;
    logic [31:0] tgt;
    m_phase = 0; m_pc = 32'h8000_0000; m_kill = 1'b0; m_fresh = 1'b1;
    m_inst = 32'd0; m_ipc = 32'd0;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (rst) begin
        chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        m_phase = 0; m_pc = 32'h8000_0000; m_kill = 1'b0; m_fresh = 1'b1;
        m_inst = 32'd0; m_ipc = 32'd0;
      end else begin
        exp_req = (m_phase == 0) && !m_fresh;
        exp_iv  = (m_phase == 2);
        chk("model_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_req});
        chk("model_inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
        if (exp_req) chk("model_req_addr", mem_req_addr, m_pc);
        if (exp_iv) begin
          chk("model_inst", inst, m_inst);
          chk("model_inst_pc", inst_pc, m_ipc);
        end
        tgt = pc_jmp_val & 32'hFFFF_FFFC;
        if (m_phase == 0) begin
          if (exp_req && mem_req_ready) begin
            m_phase = 1;
            if (pc_jmp_en) begin m_kill = 1'b1; m_pc = tgt; end
          end else if (pc_jmp_en) begin
            m_pc = tgt;
          end
        end else if (m_phase == 1) begin
          if (mem_rsp_valid) begin
            if (m_kill || pc_jmp_en) begin
              m_kill = 1'b0;
              m_phase = 0;
              if (pc_jmp_en) m_pc = tgt;
            end else begin
              m_phase = 2;
              m_inst = mem_rsp_data;
              m_ipc = m_pc;
            end
          end else if (pc_jmp_en) begin
            m_kill = 1'b1;
            m_pc = tgt;
          end
        end else begin
          if (pc_jmp_en) begin
            m_phase = 0;
            m_pc = tgt;
          end else if (inst_ready) begin
            m_phase = 0;
            m_pc = m_pc + 32'd4;
          end
        end
        m_fresh = 1'b0;
      end
    end
  end

  initial begin
    int t0, t1, t2, d0;
    errors = 0; checks = 0; done = 1'b0;
    cyc = 0; delivered = 0; mem_last_addr = 32'd0;
    rst = 1'b1; pc_jmp_en = 1'b0; pc_jmp_val = 32'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; inst_ready = 1'b0;
    auto_mem = 1'b1; rsp_data_drv = 32'd0;

    // Reset state, then zero-wait streaming
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_inst_pc", inst_pc, 32'd0);
    tick;
    rst = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("release_req_low", {31'd0, mem_req_valid}, 32'd0);
    tick;
    @(negedge clk);
    chk("first_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("first_req_addr", mem_req_addr, 32'h8000_0000);
    wait_for_inst(t0);
    chk("stream0_pc", inst_pc, 32'h8000_0000);
    chk("stream0_inst", inst, 32'h9234_5678);
    wait_for_inst(t1);
    chk("stream1_pc", inst_pc, 32'h8000_0004);
    chk("stream1_inst", inst, 32'h9234_567C);
    wait_for_inst(t2);
    chk("stream2_pc", inst_pc, 32'h8000_0008);
    chk("stream2_inst", inst, 32'h9234_5670);
    chk("stream_gap1", 32'(t1 - t0), 32'd3);
    chk("stream_gap2", 32'(t2 - t1), 32'd3);

    // Memory not ready for 4 cycles: request held stable
    tick;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      @(negedge clk);
      chk("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("stall_req_addr", mem_req_addr, 32'h8000_000C);
    end
    tick;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stall_release_valid", {31'd0, mem_req_valid}, 32'd1);
    tick;
    @(negedge clk);
    chk("single_req_wait", {31'd0, mem_req_valid}, 32'd0);

    // Decode back-pressure for 5 cycles in HOLD
    tick;
    inst_ready = 1'b0; mem_rsp_valid = 1'b1;
    tick;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      @(negedge clk);
      chk("hold_valid", {31'd0, inst_valid}, 32'd1);
      chk("hold_inst", inst, 32'h9234_5674);
      chk("hold_pc", inst_pc, 32'h8000_000C);
      chk("hold_no_req", {31'd0, mem_req_valid}, 32'd0);
    end
    tick;
    inst_ready = 1'b1;
    tick;
    inst_ready = 1'b0;
    @(negedge clk);
    chk("after_hold_addr", mem_req_addr, 32'h8000_0010);

    // Redirect while waiting: the response is dropped
    tick;
    pc_jmp_en = 1'b1; pc_jmp_val = 32'h8000_0102;
    tick;
    pc_jmp_en = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b1;
    auto_mem = 1'b0; rsp_data_drv = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("kill_no_inst", {31'd0, inst_valid}, 32'd0);
    tick;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("kill_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("kill_req_addr", mem_req_addr, 32'h8000_0100);
    chk("kill_still_no_inst", {31'd0, inst_valid}, 32'd0);

    // Redirect in HOLD without an inst handshake: instruction dropped
    tick;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; auto_mem = 1'b1;
    wait_for_inst(t0);
    chk("hold_a_pc", inst_pc, 32'h8000_0100);
    chk("hold_a_inst", inst, 32'h9234_5778);
    d0 = delivered;
    tick;
    pc_jmp_en = 1'b1; pc_jmp_val = 32'h8000_0200; mem_req_ready = 1'b0;
    tick;
    pc_jmp_en = 1'b0;
    @(negedge clk);
    chk("redir_a_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("redir_a_addr", mem_req_addr, 32'h8000_0200);
    chk("redir_a_dropped", 32'(delivered), 32'(d0));

    // Redirect in HOLD with a simultaneous inst handshake: instruction delivered
    tick;
    mem_req_ready = 1'b1;
    wait_for_inst(t0);
    chk("hold_b_pc", inst_pc, 32'h8000_0200);
    chk("hold_b_inst", inst, 32'h9234_5478);
    tick;
    pc_jmp_en = 1'b1; pc_jmp_val = 32'h8000_0200; inst_ready = 1'b1; mem_req_ready = 1'b0;
    tick;
    pc_jmp_en = 1'b0; inst_ready = 1'b0;
    @(negedge clk);
    chk("redir_b_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("redir_b_addr", mem_req_addr, 32'h8000_0200);
    chk("redir_b_delivered", 32'(delivered), 32'(d0 + 1));

    // PC wrap at the top of the address space
    tick;
    pc_jmp_en = 1'b1; pc_jmp_val = 32'hFFFF_FFFF;
    tick;
    pc_jmp_en = 1'b0; mem_req_ready = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    chk("wrap_req_addr", mem_req_addr, 32'hFFFF_FFFC);
    wait_for_inst(t0);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    tick;
    mem_req_ready = 1'b0;
    @(negedge clk);
    chk("wrap_next_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("wrap_next_addr", mem_req_addr, 32'h0000_0000);

    // Asynchronous reset while waiting
    tick;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("async_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("async_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_inst", inst, 32'd0);
    chk("async_inst_pc", inst_pc, 32'd0);
    tick;
    tick;
    rst = 1'b0; mem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("restart_req_low", {31'd0, mem_req_valid}, 32'd0);
    tick;
    @(negedge clk);
    chk("restart_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("restart_req_addr", mem_req_addr, 32'h8000_0000);

    // Randomized traffic, checked every cycle by the model
    auto_mem = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick;
      if (rst) begin
        if ($urandom_range(0, 1) == 0) rst = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
      end
      pc_jmp_en     = ($urandom_range(0, 7) == 0);
      pc_jmp_val    = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                                  : $urandom;
      mem_req_ready = ($urandom_range(0, 3) != 0);
      mem_rsp_valid = ($urandom_range(0, 2) != 0);
      rsp_data_drv  = $urandom;
      inst_ready    = ($urandom_range(0, 2) != 0);
    end
    tick;
    rst = 1'b0; pc_jmp_en = 1'b0;
    repeat (3) @(negedge clk);
    done = 1'b1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24120013_ifetch.md
YSYX_24120013_IFETCH -- requirements
Module: ysyx_24120013_IFETCH

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL set the first fetch address after reset.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of all address and PC ports.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the instruction width.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-006 Port pc_jmp_en, input, 1 bit, SHALL request a fetch redirect, sampled every cycle.
REQ-007 Port pc_jmp_val, input, ADDR_WIDTH, SHALL carry the redirect target.
REQ-008 Port mem_req_valid, output, 1 bit, SHALL indicate a valid fetch request.
REQ-009 Port mem_req_ready, input, 1 bit, SHALL indicate the memory accepts the request.
REQ-010 Port mem_req_addr, output, ADDR_WIDTH, SHALL carry the fetch address.
REQ-011 Port mem_rsp_valid, input, 1 bit, SHALL mark the returned instruction word as valid.
REQ-012 Port mem_rsp_data, input, DATA_WIDTH, SHALL carry the returned instruction word.
REQ-013 Port inst_valid, output, 1 bit, SHALL mark inst/inst_pc as valid to the decode stage (IDU).
REQ-014 Port inst_ready, input, 1 bit, SHALL indicate the IDU consumes the instruction.
REQ-015 Port inst, output, DATA_WIDTH, SHALL carry the fetched instruction.
REQ-016 Port inst_pc, output, ADDR_WIDTH, SHALL carry the address inst was fetched from.

Function
REQ-017 The FSM SHALL have three states: REQ (mem_req_valid=1), WAIT (awaiting response), HOLD (inst_valid=1).
REQ-018 Fetch PC register: the address presented in REQ; request handshake = mem_req_valid && mem_req_ready.
REQ-019 REQ: on handshake -> WAIT, with mem_req_addr frozen as the in-flight PC; otherwise stay in REQ.
REQ-020 WAIT: on mem_rsp_valid with kill flag clear -> HOLD, latching mem_rsp_data into inst and the in-flight PC into inst_pc.
REQ-021 HOLD: inst and inst_pc SHALL remain stable until inst_valid && inst_ready; on that handshake, fetch PC += 4 (mod 2^ADDR_WIDTH, wraps) -> REQ.
REQ-022 Minimum latency: request accepted in cycle N, response in N+1 -> inst_valid high in N+2; zero-wait sustained throughput: one instruction per 3 cycles.
REQ-023 Redirect target: fetch PC <= {pc_jmp_val[ADDR_WIDTH-1:2], 2'b00}; low bits are ignored.
REQ-024 Redirect in REQ without handshake: stay REQ; mem_req_addr = target on the next cycle. The memory samples the address only on handshake.
REQ-025 Redirect in REQ with handshake, or in WAIT without mem_rsp_valid: set kill, fetch PC <= target; the next response SHALL be discarded; kill clears on that response, then -> REQ.
REQ-026 Redirect in WAIT coincident with mem_rsp_valid: discard the response; clear kill; -> REQ with the target.
REQ-027 Redirect in HOLD: -> REQ with the target. If the inst handshake occurs the same cycle, the instruction counts as delivered; otherwise it is dropped. There is no +4 in either case.
REQ-028 Redirect while kill is already set: fetch PC is overwritten with the newest target; kill stays set (at most one outstanding request).
REQ-029 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-030 inst_valid SHALL be high only in HOLD; mem_req_valid only in REQ.

Reset
REQ-031 While rst=1: state=REQ, fetch PC=RESET_PC, kill=0, inst=0, inst_pc=0, inst_valid=0, mem_req_valid=0.
REQ-032 mem_req_valid SHALL assert on the first rising clk edge after rst deasserts, with mem_req_addr=RESET_PC.
REQ-033 Reset asserted mid-transaction SHALL abandon the in-flight request; a response arriving after reset SHALL be ignored unless it arrives in WAIT (only the memory model's reset guarantees no stale response).

Verification
REQ-034 Reset release, memory always ready with 0-cycle response -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 delivered in order, inst_pc matching each, one instruction per 3 cycles.
REQ-035 mem_req_ready low for 4 cycles in REQ -> mem_req_valid held high and mem_req_addr stable throughout; a single request is issued.
REQ-036 inst_ready low for 5 cycles in HOLD -> inst/inst_pc unchanged and no new request; after inst_ready=1, the next request is to inst_pc+4.
REQ-037 Redirect to 0x8000_0102 in WAIT, then response 0xDEADBEEF -> the response is dropped, the next request is to 0x8000_0100, and inst_valid never shows 0xDEADBEEF.
REQ-038 Redirect to 0x8000_0200 in HOLD, with and without a simultaneous inst_ready -> the next request is to 0x8000_0200 in both cases; the held instruction is delivered only in the simultaneous case.
REQ-039 Fetch PC 0xFFFF_FFFC consumed -> the next request is to 0x0000_0000; rst pulsed in WAIT -> all outputs are at reset values immediately (asynchronous), and fetch restarts at RESET_PC.
